// File: rtl/vector_output_streamer_if.sv
// Bundles the CPU result port and the framed byte stream of vector_output_streamer.
// master = the streamer itself, slave = the CPU/consumer side.
interface vector_output_streamer_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int VECTOR_SIZE = 6,
    parameter int FIFO_DEPTH  = 4
);
    logic [VECTOR_SIZE*DATA_WIDTH-1:0] vectorIn;
    logic                              outFlag;
    logic [7:0]                        byteOut;
    logic                              byteValid;
    logic                              byteReady;
    logic                              overflow;
    logic                              busy;
    logic [$clog2(FIFO_DEPTH+1)-1:0]   fifoCount;

    modport master (
        input  vectorIn, outFlag, byteReady,
        output byteOut, byteValid, overflow, busy, fifoCount
    );

    modport slave (
        output vectorIn, outFlag, byteReady,
        input  byteOut, byteValid, overflow, busy, fifoCount
    );
endinterface

// File: rtl/vector_output_streamer.sv
// Captures flagged CPU result vectors into a small FIFO and streams each one
// as a HEADER byte followed by its bytes, low byte of element 0 first.
module vector_output_streamer #(
    parameter int          DATA_WIDTH  = 16,
    parameter int          VECTOR_SIZE = 6,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [7:0]  HEADER      = 8'hA5
) (
    input  logic                     clock,
    input  logic                     reset,
    vector_output_streamer_if.master bus
);
    localparam int VW     = VECTOR_SIZE * DATA_WIDTH;
    localparam int NBYTES = VW / 8;
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int CW     = $clog2(FIFO_DEPTH + 1);
    localparam int IW     = $clog2(NBYTES);

    typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_DATA} state_t;

    state_t          state_reg, state_next;
    logic [VW-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [VW-1:0]   shift_reg;
    logic [IW-1:0]   idx_reg;
    logic [7:0]      byte_reg, byte_next;
    logic            overflow_reg;

    logic            valid;
    logic            xfer;
    logic            last;
    logic            have;
    logic            full;
    logic            pop;
    logic            push;

    assign valid = (state_reg != ST_IDLE);
    assign xfer  = valid && bus.byteReady;
    assign last  = (idx_reg == IW'(NBYTES - 1));
    assign have  = (count_reg != '0);
    assign full  = (count_reg == CW'(FIFO_DEPTH));
    // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
    assign push  = bus.outFlag && (!full || pop);

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        byte_next  = byte_reg;
        case (state_reg)
            ST_IDLE: begin
                if (have) begin
                    pop        = 1'b1;
                    state_next = ST_HEADER;
                    byte_next  = HEADER;
                end
            end
            ST_HEADER: begin
                if (xfer) begin
                    state_next = ST_DATA;
                    byte_next  = shift_reg[7:0];
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    if (!last) begin
                        byte_next = shift_reg[15:8];
                    end else if (have) begin
                        // Back-to-back frames: next header follows with no idle gap.
                        pop        = 1'b1;
                        state_next = ST_HEADER;
                        byte_next  = HEADER;
                    end else begin
                        state_next = ST_IDLE;
                        byte_next  = 8'h00;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                byte_next  = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            shift_reg    <= '0;
            idx_reg      <= '0;
            byte_reg     <= 8'h00;
            overflow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            byte_reg  <= byte_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            if (bus.outFlag && !push) overflow_reg <= 1'b1;
            if (pop) begin
                shift_reg <= mem[rd_ptr_reg];
                idx_reg   <= '0;
            end else if (state_reg == ST_DATA && xfer && !last) begin
                shift_reg <= shift_reg >> 8;
                idx_reg   <= idx_reg + IW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_reg] <= bus.vectorIn;
    end

    assign bus.byteOut   = byte_reg;
    assign bus.byteValid = valid;
    assign bus.overflow  = overflow_reg;
    assign bus.busy      = valid || have;
    assign bus.fifoCount = count_reg;
endmodule

// File: tb/tb_vector_output_streamer.sv
// Self-checking bench for vector_output_streamer: directed corner sequences,
// a stimulus table for FIFO fill/overflow, and a randomized run against a byte-queue model.
module tb_vector_output_streamer;
    localparam int DW    = 16;
    localparam int VS    = 6;
    localparam int DEPTH = 4;
    localparam int VW    = DW * VS;
    localparam int NB    = VW / 8;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] expq[$];
    logic       stall_prev = 1'b0;
    logic [7:0] stall_byte = 8'h00;

    vector_output_streamer_if #(.DATA_WIDTH(DW), .VECTOR_SIZE(VS), .FIFO_DEPTH(DEPTH)) intf ();

    vector_output_streamer #(
        .DATA_WIDTH(DW), .VECTOR_SIZE(VS), .FIFO_DEPTH(DEPTH), .HEADER(8'hA5)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (intf.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic flag;
        logic ready;
        logic accept;
        int   exp_count;
        logic exp_valid;
        logic exp_ovf;
    } row_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end else begin
            $display("ok   %s: %0h", name, got);
        end
    endtask

    // Reference model: a frame is the header followed by the vector's bytes, lowest first.
    function automatic void expect_frame(input logic [VW-1:0] v);
        expq.push_back(8'hA5);
        for (int k = 0; k < NB; k++) expq.push_back(v[8*k +: 8]);
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic step(input logic f, input logic [VW-1:0] v, input logic r);
        intf.outFlag   = f;
        intf.vectorIn  = v;
        intf.byteReady = r;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        intf.outFlag   = 1'b0;
        intf.byteReady = 1'b0;
        intf.vectorIn  = '0;
        expq.delete();
        #17;
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 600 && (expq.size() != 0 || intf.busy); i++) step(1'b0, '0, 1'b1);
        check(name, expq.size(), 0);
        check({name, "_busy"}, intf.busy, 1'b0);
    endtask

    // Transfer monitor: sampled at the falling edge, between input updates and the active edge.
    always @(negedge clock) begin
        if (!reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (!(intf.byteValid && intf.byteOut == stall_byte)) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%0b byte=%02h expected valid=1 byte=%02h",
                             intf.byteValid, intf.byteOut, stall_byte);
                end
            end
            if (intf.byteValid && intf.byteReady) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got %02h expected no transfer", intf.byteOut);
                end else begin
                    logic [7:0] b;
                    b = expq.pop_front();
                    if (intf.byteOut !== b) begin
                        errors++;
                        $display("FAIL stream_byte: got %02h expected %02h", intf.byteOut, b);
                    end else begin
                        $display("xfer byte %02h", b);
                    end
                end
            end
            stall_prev = intf.byteValid && !intf.byteReady;
            stall_byte = intf.byteOut;
        end
    end

    initial begin
        logic [VW-1:0] v;
        logic [7:0]    fb [NB+1];
        row_t          tbl [6];
        int            nv, first, last;

        reset          = 1'b0;
        intf.outFlag   = 1'b0;
        intf.byteReady = 1'b0;
        intf.vectorIn  = '0;
        #22;
        check("rst_valid", intf.byteValid, 1'b0);
        check("rst_byte",  intf.byteOut,   8'h00);
        check("rst_count", intf.fifoCount, 0);
        check("rst_ovf",   intf.overflow,  1'b0);
        check("rst_busy",  intf.busy,      1'b0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Single vector with elements 0..5, consumer always ready.
        for (int e = 0; e < VS; e++) v[DW*e +: DW] = DW'(e);
        fb[0] = 8'hA5;
        for (int k = 0; k < NB; k++) fb[k+1] = v[8*k +: 8];
        expect_frame(v);
        step(1'b1, v, 1'b1);
        check("t1_latency_idle", intf.byteValid, 1'b0);
        for (int i = 0; i <= NB; i++) begin
            step(1'b0, '0, 1'b1);
            check($sformatf("t1_valid_%0d", i), intf.byteValid, 1'b1);
            check($sformatf("t1_byte_%0d", i),  intf.byteOut,   fb[i]);
        end
        step(1'b0, '0, 1'b1);
        check("t1_end_valid", intf.byteValid, 1'b0);
        check("t1_end_busy",  intf.busy,      1'b0);

        // Same vector, consumer ready half the time; monitor checks bytes and stall holding.
        expect_frame(v);
        step(1'b1, v, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 200 && (expq.size() != 0 || intf.busy); i++)
            step(1'b0, '0, 1'($urandom_range(0, 1)));
        drain("t2_drain");

        // Four back-to-back vectors must stream as 52 contiguous bytes.
        nv = 0; first = -1; last = -1;
        for (int i = 0; i < 80; i++) begin
            if (i < 4) begin
                v = rand_vec();
                expect_frame(v);
                step(1'b1, v, 1'b1);
            end else begin
                step(1'b0, '0, 1'b1);
            end
            if (intf.byteValid) begin
                nv++;
                if (first < 0) first = i;
                last = i;
            end
        end
        check("t3_bytes", nv, 4 * (NB + 1));
        check("t3_contiguous", last - first + 1, 4 * (NB + 1));
        check("t3_ovf", intf.overflow, 1'b0);
        drain("t3_drain");

        // Table: stalled consumer, six pushes; the sixth overflows.
        do_reset();
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 2, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 3, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 4, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 4, 1'b1, 1'b1};
        for (int r = 0; r < 6; r++) begin
            v = rand_vec();
            if (tbl[r].accept) expect_frame(v);
            step(tbl[r].flag, v, tbl[r].ready);
            check($sformatf("t4_count_%0d", r), intf.fifoCount, tbl[r].exp_count);
            check($sformatf("t4_valid_%0d", r), intf.byteValid, tbl[r].exp_valid);
            check($sformatf("t4_ovf_%0d", r),   intf.overflow,  tbl[r].exp_ovf);
        end
        drain("t4_drain");
        check("t4_ovf_sticky", intf.overflow, 1'b1);

        // Full FIFO, push lands on the edge of the final data byte transfer.
        do_reset();
        for (int r = 0; r < 5; r++) begin
            v = rand_vec();
            expect_frame(v);
            step(tbl[r].flag, v, tbl[r].ready);
            check($sformatf("t5_fill_%0d", r), intf.fifoCount, tbl[r].exp_count);
        end
        for (int i = 0; i < NB; i++) step(1'b0, '0, 1'b1);
        check("t5_pre_count", intf.fifoCount, DEPTH);
        v = rand_vec();
        expect_frame(v);
        step(1'b1, v, 1'b1);
        check("t5_count", intf.fifoCount, DEPTH);
        check("t5_ovf",   intf.overflow,  1'b0);
        check("t5_hdr",   intf.byteOut,   8'hA5);
        drain("t5_drain");
        check("t5_ovf_end", intf.overflow, 1'b0);

        // Asynchronous reset after the fifth byte of a frame.
        do_reset();
        v = rand_vec(); expect_frame(v); step(1'b1, v, 1'b1);
        v = rand_vec(); expect_frame(v); step(1'b1, v, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
        check("t6_pre_count", intf.fifoCount, 1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_valid", intf.byteValid, 1'b0);
        check("t6_count", intf.fifoCount, 0);
        expq.delete();
        #20;
        reset = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1);
        check("t6_quiet_valid", intf.byteValid, 1'b0);
        check("t6_quiet_busy",  intf.busy,      1'b0);

        // Randomized traffic kept below the overflow threshold.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            logic f;
            f = ((expq.size() + NB) / (NB + 1) < DEPTH) && ($urandom_range(0, 3) == 0);
            v = rand_vec();
            if (f) expect_frame(v);
            step(f, v, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 600 && (expq.size() != 0 || intf.busy); i++)
            step(1'b0, '0, 1'($urandom_range(0, 1)));
        drain("rand_drain");
        check("rand_ovf", intf.overflow, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
